lcd_8_to_32_bits_dfa_packer: RTL and testbench
==============================================

// Module: lcd_8_to_32_bits_dfa_packer
// PURPOSE
//  Avalon-ST data format adapter, 8-bit symbols in, 32-bit words out; reverse of the 32->8 LCD path.
//  Packs 4 bytes per channel into one word, first byte in out_data[31:24] (big-endian).
//  Keeps per-channel partial-word state so byte streams from different channels can interleave.
//  Sits between the byte-wide LCD/DMA-side source and the 32-bit pixel buffer sink.
// PARAMETERS
//  CHANNEL_WIDTH  1  width of in_channel/out_channel; CHANNELS = 2**CHANNEL_WIDTH state entries
// PORTS
//  clk               in   1   single clock for the whole block
//  reset_n           in   1   asynchronous assert, active-low reset
//  in_data           in   8   input symbol
//  in_valid          in   1   input symbol valid
//  in_ready          out  1   sink ready; transfer when in_valid & in_ready
//  in_channel        in   CW  channel of input symbol
//  in_startofpacket  in   1   first byte of packet   [LCD_DFA_PACKETS_EN only]
//  in_endofpacket    in   1   last byte of packet    [LCD_DFA_PACKETS_EN only]
//  out_data          out  32  packed word
//  out_valid         out  1   word valid
//  out_ready         in   1   downstream ready; transfer when out_valid & out_ready
//  out_channel       out  CW  channel of word
//  out_startofpacket out  1   word holds an SOP byte  [LCD_DFA_PACKETS_EN only]
//  out_endofpacket   out  1   word holds the EOP byte [LCD_DFA_PACKETS_EN only]
//  out_empty         out  2   unused low bytes of last word [LCD_DFA_PACKETS_EN only]
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_channel=0, out_sop/eop=0, out_empty=0, in_ready=0.
//    All per-channel state (count=0, partial=0, sop=0) cleared asynchronously.
//  - in_ready goes 1 on the first clk after reset_n deasserts. It then equals ~out_valid | out_ready.
//  - Per-channel state: count[1:0] = bytes held, partial[23:0], sop_seen.
//    The accepted byte goes to byte lane (3-count). A byte with count==3 completes the word.
//  - Completing a word loads the output register on the same edge. out_valid rises 1 clk after the 4th byte is accepted.
//    The channel's count returns to 0 on that edge.
//  - Output register holds data/channel/flags stable while out_valid & ~out_ready.
//    It reloads on the same edge that the previous word drains (no bubble): 1 byte/clk sustained.
//  - Only the addressed channel's state changes per edge. Other channels are untouched (interleave-safe).
//  - Arithmetic: count wraps 3->0 only on word completion. Widths are fixed, with no overflow paths.
//  - Reset mid-word: partial bytes are discarded. A pending output word is lost.
// CONFIGURATION
//  LCD_DFA_PACKETS_EN defined:
//    - SOP/EOP/empty ports present.
//    - in_eop with count==n-1 (n=1..4 bytes) emits the word immediately.
//      The word is left-aligned, unused low lanes are 0, and out_empty=4-n. Count resets to 0.
//    - in_sop on a channel with count!=0 drops the stale partial and restarts at lane 3.
//    - out_startofpacket=1 on the word containing the SOP byte.
//    - Single-byte packet (sop&eop): out_empty=3, sop=eop=1.
//  LCD_DFA_PACKETS_EN undefined:
//    - No SOP/EOP/empty ports. Only full 4-byte words are emitted.
//    - Partials wait indefinitely.
// STRUCTURE
//  - Shared package lcd_dfa_pkg: SYMBOL_W=8, SYMBOLS_PER_WORD=4, EMPTY_W=2, typedef of the per-channel state record
//    (count, partial, sop_seen), lane-index function.
//  - One sub-module: lcd_8_to_32_bits_dfa_chan_state.
//    Register array of CHANNELS records with a combinational read on in_channel.
//    Write-enable plus write-record update on accept, with async clear.
//  - Top level holds the accept logic, lane insertion, and the output register/handshake.
// TESTING
//  1. Reset: reset_n=0 -> out_valid=0, in_ready=0. Release -> in_ready=1 next clk.
//  2. Bytes 0x11,0x22,0x33,0x44 on ch0, out_ready=1 -> out_data=32'h11223344, out_channel=0, 1 clk after the 4th byte.
//  3. Interleave ch0:AA, ch1:01, ch0:BB, ch1:02 ... -> ch0 word AABBCCDD and ch1 word 01020304, each emitted intact.
//  4. out_ready=0 for 5 clks with a word pending -> out_data stable, in_ready=0. Release -> 1 byte/clk resumes with no lost byte.
//  5. [PACKETS_EN] sop 0x10, 0x20, eop 0x30 -> out_data=32'h10203000, out_empty=1, sop=eop=1.
//  6. [PACKETS_EN] 2 bytes on ch1, then a new SOP byte 0x55 on ch1 -> partial dropped.
//     The next full word starts with 0x55 and has out_startofpacket=1.

Source files
------------

// File: rtl/lcd_dfa_pkg.sv
// Shared constants, per-channel partial-word record and lane helper for the 8->32 packer.
package lcd_dfa_pkg;

    localparam int SYMBOL_W         = 8;
    localparam int SYMBOLS_PER_WORD = 4;
    localparam int EMPTY_W          = 2;
    localparam int WORD_W           = SYMBOL_W * SYMBOLS_PER_WORD;
    localparam int PARTIAL_W        = WORD_W - SYMBOL_W;

    typedef struct packed {
        logic [1:0]           count;
        logic [PARTIAL_W-1:0] partial;
        logic                 sop_seen;
    } chan_rec_t;

    localparam int REC_W = $bits(chan_rec_t);

    // Byte lane a symbol lands in, given how many bytes the channel already holds.
    function automatic logic [1:0] lane_idx(input logic [1:0] count);
        return 2'd3 - count;
    endfunction

endpackage

// File: rtl/lcd_8_to_32_bits_dfa_chan_state.sv
// Per-channel partial-word record store: combinational read and single write port on one channel index.
// State clears asynchronously; only the addressed record is written on an enabled edge.
module lcd_8_to_32_bits_dfa_chan_state
    import lcd_dfa_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNEL_WIDTH-1:0] i_chan,
    input  logic                     i_wr_en,
    input  logic [REC_W-1:0]         i_wr_rec,
    output logic [REC_W-1:0]         o_rd_rec
);

    localparam int CHANNELS = 2 ** CHANNEL_WIDTH;

    chan_rec_t r_mem [CHANNELS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_chan] <= chan_rec_t'(i_wr_rec);
        end
    end

    assign o_rd_rec = r_mem[i_chan];

endmodule

// File: rtl/lcd_8_to_32_bits_dfa_packer.sv
// Avalon-ST 8->32 packer with per-channel partial words, big-endian lanes, 1 byte/clk, out_valid 1 clk after last byte.
// Optional packet support (SOP/EOP/empty, short final words) under LCD_DFA_PACKETS_EN.
module lcd_8_to_32_bits_dfa_packer
    import lcd_dfa_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
`ifdef LCD_DFA_PACKETS_EN
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [1:0]               out_empty,
`endif
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    logic                     r_started;
    logic                     r_out_valid;
    logic [WORD_W-1:0]        r_out_data;
    logic [CHANNEL_WIDTH-1:0] r_out_channel;

    logic                     w_accept;
    logic [REC_W-1:0]         w_rd_bits;
    chan_rec_t                w_rd_rec;
    chan_rec_t                w_wr_rec;
    logic [1:0]               w_count;
    logic [PARTIAL_W-1:0]     w_partial;
    logic                     w_sop;
    logic                     w_last;
    logic [WORD_W-1:0]        w_word;

    lcd_8_to_32_bits_dfa_chan_state #(
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_chan_state (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_chan   (in_channel),
        .i_wr_en  (w_accept),
        .i_wr_rec (w_wr_rec),
        .o_rd_rec (w_rd_bits)
    );

    assign w_rd_rec = chan_rec_t'(w_rd_bits);

    // The output register can always take a new word when the input is ready.
    assign in_ready = r_started & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_count   = w_rd_rec.count;
        w_partial = w_rd_rec.partial;
        w_sop     = w_rd_rec.sop_seen;
`ifdef LCD_DFA_PACKETS_EN
        // A new SOP discards whatever stale partial the channel was holding.
        if (in_startofpacket) begin
            w_count   = '0;
            w_partial = '0;
            w_sop     = 1'b1;
        end
        w_last = (w_count == 2'd3) | in_endofpacket;
`else
        w_last = (w_count == 2'd3);
`endif
        w_word = {w_partial, {SYMBOL_W{1'b0}}};
        w_word[{lane_idx(w_count), 3'b000} +: SYMBOL_W] = in_data;

        w_wr_rec = '0;
        if (!w_last) begin
            w_wr_rec.count    = w_count + 2'd1;
            w_wr_rec.partial  = w_word[WORD_W-1:SYMBOL_W];
            w_wr_rec.sop_seen = w_sop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
        end else if (w_accept && w_last) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_word;
            r_out_channel <= in_channel;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

`ifdef LCD_DFA_PACKETS_EN
    logic             r_out_sop;
    logic             r_out_eop;
    logic [EMPTY_W-1:0] r_out_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else if (w_accept && w_last) begin
            r_out_sop   <= w_sop;
            r_out_eop   <= in_endofpacket;
            r_out_empty <= 2'd3 - w_count;
        end
    end

    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
`endif

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;

endmodule

// File: tb/tb_lcd_8_to_32_bits_dfa_packer.sv
// Directed bench for the 8->32 packer; packet steps are built only when LCD_DFA_PACKETS_EN is defined.
module tb_lcd_8_to_32_bits_dfa_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_channel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_channel;
`ifdef LCD_DFA_PACKETS_EN
    logic        in_sop;
    logic        in_eop;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_8_to_32_bits_dfa_packer #(
        .CHANNEL_WIDTH (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_channel        (in_channel),
`ifdef LCD_DFA_PACKETS_EN
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
`endif
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_channel       (out_channel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic [7:0] d);
        in_valid   = 1'b1;
        in_data    = d;
        in_channel = ch;
`ifdef LCD_DFA_PACKETS_EN
        in_sop = 1'b0;
        in_eop = 1'b0;
`endif
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        step();
    endtask

`ifdef LCD_DFA_PACKETS_EN
    task automatic psend(input logic ch, input logic [7:0] d, input logic sop, input logic eop);
        in_valid   = 1'b1;
        in_data    = d;
        in_channel = ch;
        in_sop     = sop;
        in_eop     = eop;
        chk("psend_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask
`endif

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_channel = 1'b0;
        out_ready  = 1'b0;
`ifdef LCD_DFA_PACKETS_EN
        in_sop = 1'b0;
        in_eop = 1'b0;
`endif
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_channel", {31'd0, out_channel}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
        step();
        chk("rel_in_ready_post", {31'd0, in_ready}, 32'd1);

        // Single channel, full word.
        out_ready = 1'b1;
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        chk("w1_partial_no_valid", {31'd0, out_valid}, 32'd0);
        send(1'b0, 8'h44);
        idle();
        chk("w1_valid", {31'd0, out_valid}, 32'd1);
        chk("w1_data", out_data, 32'h11223344);
        chk("w1_chan", {31'd0, out_channel}, 32'd0);
        step();
        chk("w1_drained", {31'd0, out_valid}, 32'd0);

        // Interleaved channels.
        send(1'b0, 8'hAA);
        send(1'b1, 8'h01);
        send(1'b0, 8'hBB);
        send(1'b1, 8'h02);
        send(1'b0, 8'hCC);
        send(1'b1, 8'h03);
        send(1'b0, 8'hDD);
        chk("il_ch0_valid", {31'd0, out_valid}, 32'd1);
        chk("il_ch0_data", out_data, 32'hAABBCCDD);
        chk("il_ch0_chan", {31'd0, out_channel}, 32'd0);
        send(1'b1, 8'h04);
        idle();
        chk("il_ch1_valid", {31'd0, out_valid}, 32'd1);
        chk("il_ch1_data", out_data, 32'h01020304);
        chk("il_ch1_chan", {31'd0, out_channel}, 32'd1);
        step();
        chk("il_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: word held stable, input stalled, then resume without loss.
        out_ready = 1'b0;
        send(1'b1, 8'hA1);
        send(1'b1, 8'hA2);
        send(1'b1, 8'hA3);
        send(1'b1, 8'hA4);
        in_valid   = 1'b1;
        in_data    = 8'h55;
        in_channel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", out_data, 32'hA1A2A3A4);
            chk("bp_chan", {31'd0, out_channel}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_release_drained", {31'd0, out_valid}, 32'd0);
        send(1'b0, 8'h66);
        send(1'b0, 8'h77);
        send(1'b0, 8'h88);
        idle();
        chk("bp_resume_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_resume_data", out_data, 32'h55667788);
        step();

        // Reset mid-word discards the partial.
        send(1'b0, 8'hE1);
        send(1'b0, 8'hE2);
        idle();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        send(1'b0, 8'hF1);
        send(1'b0, 8'hF2);
        send(1'b0, 8'hF3);
        send(1'b0, 8'hF4);
        idle();
        chk("mid_rst_word", out_data, 32'hF1F2F3F4);
        chk("mid_rst_word_valid", {31'd0, out_valid}, 32'd1);
        step();

`ifdef LCD_DFA_PACKETS_EN
        // Short packet: 3 bytes, empty=1.
        psend(1'b0, 8'h10, 1'b1, 1'b0);
        psend(1'b0, 8'h20, 1'b0, 1'b0);
        psend(1'b0, 8'h30, 1'b0, 1'b1);
        idle();
        chk("pk3_valid", {31'd0, out_valid}, 32'd1);
        chk("pk3_data", out_data, 32'h10203000);
        chk("pk3_empty", {30'd0, out_empty}, 32'd1);
        chk("pk3_sop", {31'd0, out_sop}, 32'd1);
        chk("pk3_eop", {31'd0, out_eop}, 32'd1);
        step();

        // Stale partial dropped by a new SOP.
        psend(1'b1, 8'hE1, 1'b1, 1'b0);
        psend(1'b1, 8'hE2, 1'b0, 1'b0);
        idle();
        chk("stale_no_valid", {31'd0, out_valid}, 32'd0);
        psend(1'b1, 8'h55, 1'b1, 1'b0);
        psend(1'b1, 8'h66, 1'b0, 1'b0);
        psend(1'b1, 8'h77, 1'b0, 1'b0);
        psend(1'b1, 8'h88, 1'b0, 1'b0);
        idle();
        chk("stale_data", out_data, 32'h55667788);
        chk("stale_sop", {31'd0, out_sop}, 32'd1);
        chk("stale_eop", {31'd0, out_eop}, 32'd0);
        chk("stale_empty", {30'd0, out_empty}, 32'd0);
        chk("stale_chan", {31'd0, out_channel}, 32'd1);
        step();

        // Single-byte packet.
        psend(1'b0, 8'h99, 1'b1, 1'b1);
        idle();
        chk("pk1_data", out_data, 32'h99000000);
        chk("pk1_empty", {30'd0, out_empty}, 32'd3);
        chk("pk1_sop", {31'd0, out_sop}, 32'd1);
        chk("pk1_eop", {31'd0, out_eop}, 32'd1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
